// File: rtl/servo_pwm_update_ctrl_if.sv
// Host-side bus of the servo PWM update controller: shadow-register writes
// plus the commit request and its pending status.
interface servo_pwm_update_ctrl_if #(
    parameter int DWIDTH = 15
);
    logic              wr_valid;
    logic              wr_ready;
    logic [2:0]        wr_sel;
    logic [DWIDTH-1:0] wr_data;
    logic              commit;
    logic              commit_pend;

    modport master (
        output wr_valid, wr_sel, wr_data, commit,
        input  wr_ready, commit_pend
    );

    modport slave (
        input  wr_valid, wr_sel, wr_data, commit,
        output wr_ready, commit_pend
    );
endinterface

// File: rtl/servo_pwm_update_ctrl.sv
// Shadow/active register controller for servo_pwmx4: atomic commits at period boundaries,
// core_en sequencing (start, 2-period graceful stop, fault kill). Option: SERVO_PWM_SOFTSTART_EN.
module servo_pwm_update_ctrl #(
    parameter int DWIDTH          = 15,
    parameter int RST_PRESCALER   = 10,
    parameter int RST_HALF_PERIOD = 100
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    servo_pwm_update_ctrl_if.slave  host_if,
    input  logic                    start_i,
    input  logic                    stop_i,
    input  logic                    fault_i,
    input  logic                    fault_clr_i,
    input  logic                    pwm_sync_i,
    output logic                    core_en_o,
    output logic [DWIDTH-1:0]       prescaler_o,
    output logic [DWIDTH-1:0]       half_period_o,
    output logic [5:0]              trig_rate_o,
    output logic [DWIDTH-1:0]       d0_o,
    output logic [DWIDTH-1:0]       d1_o,
    output logic [DWIDTH-1:0]       d2_o,
    output logic [DWIDTH-1:0]       d3_o,
    output logic [2:0]              state_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RUN        = 3'd1,
        STOP_DRAIN = 3'd2,
        STOP_OFF   = 3'd3,
        FAULT      = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   core_en_q, core_en_d;
    logic   commit_pend_q, commit_pend_d;

    logic [DWIDTH-1:0]            sh_pre_q, sh_pre_d, sh_hp_q, sh_hp_d;
    logic [5:0]                   sh_trig_q, sh_trig_d;
    logic [3:0][DWIDTH-1:0]       sh_duty_q, sh_duty_d;
    logic [DWIDTH-1:0]            act_pre_q, act_pre_d, act_hp_q, act_hp_d;
    logic [5:0]                   act_trig_q, act_trig_d;
    logic [3:0][DWIDTH-1:0]       act_duty_q, act_duty_d;
    logic [3:0][DWIDTH-1:0]       clamp;

    logic wr_acc, sync_v, apply, zero_duty;

    assign wr_acc = host_if.wr_valid & ~commit_pend_q;
    assign sync_v = pwm_sync_i & core_en_q;
    // Fault blocks the transfer; the commit stays pending until the fault level drops.
    assign apply  = commit_pend_q & ~fault_i &
                    ((state_q == IDLE) || (state_q == FAULT) || ((state_q == RUN) && sync_v));

    // FSM next state, core_en and duty zeroing
    always_comb begin
        state_d   = state_q;
        core_en_d = core_en_q;
        zero_duty = 1'b0;
        if (fault_i) begin
            state_d   = FAULT;
            core_en_d = 1'b0;
            zero_duty = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (start_i && !stop_i) begin
                    state_d   = RUN;
                    core_en_d = 1'b1;
                end
                RUN:        if (stop_i) state_d = STOP_DRAIN;
                STOP_DRAIN: if (sync_v) begin
                    state_d   = STOP_OFF;
                    zero_duty = 1'b1;
                end
                STOP_OFF:   if (sync_v) begin
                    state_d   = IDLE;
                    core_en_d = 1'b0;
                end
                FAULT:      if (fault_clr_i) state_d = IDLE;
                default: begin
                    state_d   = IDLE;
                    core_en_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        commit_pend_d = commit_pend_q;
        if (apply)
            commit_pend_d = 1'b0;
        else if (host_if.commit && !fault_i)
            commit_pend_d = 1'b1;
    end

    // Shadow writes; wr_sel=7 is accepted but lands nowhere
    always_comb begin
        sh_pre_d  = sh_pre_q;
        sh_hp_d   = sh_hp_q;
        sh_trig_d = sh_trig_q;
        sh_duty_d = sh_duty_q;
        if (wr_acc) begin
            case (host_if.wr_sel)
                3'd0, 3'd1, 3'd2, 3'd3: sh_duty_d[host_if.wr_sel[1:0]] = host_if.wr_data;
                3'd4:    sh_hp_d   = host_if.wr_data;
                3'd5:    sh_pre_d  = host_if.wr_data;
                3'd6:    sh_trig_d = host_if.wr_data[5:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++)
            clamp[n] = (sh_duty_q[n] > sh_hp_q) ? sh_hp_q : sh_duty_q[n];
    end

    always_comb begin
        act_pre_d  = act_pre_q;
        act_hp_d   = act_hp_q;
        act_trig_d = act_trig_q;
        if (apply) begin
            act_pre_d  = sh_pre_q;
            act_hp_d   = sh_hp_q;
            act_trig_d = sh_trig_q;
        end
    end

`ifdef SERVO_PWM_SOFTSTART_EN
    logic [3:0][DWIDTH-1:0] tgt_q, tgt_d;
    logic [DWIDTH-1:0]      step;

    assign step = (act_hp_q[DWIDTH-1:4] == '0) ? DWIDTH'(1) : (act_hp_q >> 4);

    // In RUN each sync slews the duty toward its target; elsewhere applies jump.
    always_comb begin
        tgt_d      = tgt_q;
        act_duty_d = act_duty_q;
        for (int n = 0; n < 4; n++) begin
            if (zero_duty) begin
                tgt_d[n]      = '0;
                act_duty_d[n] = '0;
            end else begin
                if (apply) tgt_d[n] = clamp[n];
                if (apply && state_q != RUN) begin
                    act_duty_d[n] = clamp[n];
                end else if (state_q == RUN && sync_v) begin
                    if (act_duty_q[n] < tgt_d[n])
                        act_duty_d[n] = ((tgt_d[n] - act_duty_q[n]) > step) ?
                                        act_duty_q[n] + step : tgt_d[n];
                    else if (act_duty_q[n] > tgt_d[n])
                        act_duty_d[n] = ((act_duty_q[n] - tgt_d[n]) > step) ?
                                        act_duty_q[n] - step : tgt_d[n];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) tgt_q <= '0;
        else         tgt_q <= tgt_d;
    end
`else
    always_comb begin
        act_duty_d = act_duty_q;
        for (int n = 0; n < 4; n++) begin
            if (zero_duty)  act_duty_d[n] = '0;
            else if (apply) act_duty_d[n] = clamp[n];
        end
    end
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            core_en_q     <= 1'b0;
            commit_pend_q <= 1'b0;
            sh_pre_q      <= DWIDTH'(RST_PRESCALER);
            sh_hp_q       <= DWIDTH'(RST_HALF_PERIOD);
            sh_trig_q     <= '0;
            sh_duty_q     <= '0;
            act_pre_q     <= DWIDTH'(RST_PRESCALER);
            act_hp_q      <= DWIDTH'(RST_HALF_PERIOD);
            act_trig_q    <= '0;
            act_duty_q    <= '0;
        end else begin
            state_q       <= state_d;
            core_en_q     <= core_en_d;
            commit_pend_q <= commit_pend_d;
            sh_pre_q      <= sh_pre_d;
            sh_hp_q       <= sh_hp_d;
            sh_trig_q     <= sh_trig_d;
            sh_duty_q     <= sh_duty_d;
            act_pre_q     <= act_pre_d;
            act_hp_q      <= act_hp_d;
            act_trig_q    <= act_trig_d;
            act_duty_q    <= act_duty_d;
        end
    end

    assign host_if.wr_ready    = ~commit_pend_q;
    assign host_if.commit_pend = commit_pend_q;
    assign core_en_o           = core_en_q;
    assign prescaler_o         = act_pre_q;
    assign half_period_o       = act_hp_q;
    assign trig_rate_o         = act_trig_q;
    assign d0_o                = act_duty_q[0];
    assign d1_o                = act_duty_q[1];
    assign d2_o                = act_duty_q[2];
    assign d3_o                = act_duty_q[3];
    assign state_o             = state_q;

endmodule

// File: tb/tb_servo_pwm_update_ctrl.sv
// Self-checking bench for servo_pwm_update_ctrl: table-driven idle commits with a
// scoreboard queue, plus directed run/stop/fault/reset sequences.
module tb_servo_pwm_update_ctrl;

    localparam int DW = 15;

    logic clk, reset;
    logic start, stop, fault, fault_clr, pwm_sync;
    logic core_en;
    logic [DW-1:0] prescaler, half_period, d0, d1, d2, d3;
    logic [5:0] trig_rate;
    logic [2:0] state;

    int n_chk  = 0;
    int n_pass = 0;

    servo_pwm_update_ctrl_if #(.DWIDTH(DW)) hif ();

    servo_pwm_update_ctrl dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .host_if       (hif),
        .start_i       (start),
        .stop_i        (stop),
        .fault_i       (fault),
        .fault_clr_i   (fault_clr),
        .pwm_sync_i    (pwm_sync),
        .core_en_o     (core_en),
        .prescaler_o   (prescaler),
        .half_period_o (half_period),
        .trig_rate_o   (trig_rate),
        .d0_o          (d0),
        .d1_o          (d1),
        .d2_o          (d2),
        .d3_o          (d3),
        .state_o       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    sel;
        logic [DW-1:0] data;
        logic [DW-1:0] pre;
        logic [DW-1:0] hp;
        logic [5:0]    trig;
        logic [DW-1:0] e0, e1, e2, e3;
    } vec_t;

    vec_t tbl [11];
    vec_t sbq [$];
    vec_t ex;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        hif.wr_valid = 1'b0;
        hif.wr_sel   = 3'd0;
        hif.wr_data  = '0;
        hif.commit   = 1'b0;
        start = 1'b0; stop = 1'b0; fault = 1'b0; fault_clr = 1'b0; pwm_sync = 1'b0;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [DW-1:0] data, input logic cmt);
        hif.wr_valid = 1'b1;
        hif.wr_sel   = sel;
        hif.wr_data  = data;
        hif.commit   = cmt;
        tick();
        clr_inputs();
    endtask

    task automatic sync_pulse();
        pwm_sync = 1'b1;
        tick();
        pwm_sync = 1'b0;
    endtask

    task automatic check_duties(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [DW-1:0] c, input logic [DW-1:0] e);
        check({name, ".d0"}, 32'(d0), 32'(a));
        check({name, ".d1"}, 32'(d1), 32'(b));
        check({name, ".d2"}, 32'(d2), 32'(c));
        check({name, ".d3"}, 32'(d3), 32'(e));
    endtask

    initial begin
        int exp_d;
        //          sel   data       pre  hp   trig   d0   d1  d2  d3
        tbl[0]  = '{3'd0, 15'd50,    10, 100, 6'h00,  50,   0,  0,  0};
        tbl[1]  = '{3'd1, 15'd50,    10, 100, 6'h00,  50,  50,  0,  0};
        tbl[2]  = '{3'd2, 15'd50,    10, 100, 6'h00,  50,  50, 50,  0};
        tbl[3]  = '{3'd3, 15'd50,    10, 100, 6'h00,  50,  50, 50, 50};
        tbl[4]  = '{3'd5, 15'd20,    20, 100, 6'h00,  50,  50, 50, 50};
        tbl[5]  = '{3'd6, 15'h01FF,  20, 100, 6'h3F,  50,  50, 50, 50};
        tbl[6]  = '{3'd7, 15'd123,   20, 100, 6'h3F,  50,  50, 50, 50};
        tbl[7]  = '{3'd0, 15'h7FFF,  20, 100, 6'h3F, 100,  50, 50, 50};
        tbl[8]  = '{3'd4, 15'd40,    20,  40, 6'h3F,  40,  40, 40, 40};
        tbl[9]  = '{3'd4, 15'd100,   20, 100, 6'h3F, 100,  50, 50, 50};
        tbl[10] = '{3'd0, 15'd50,    20, 100, 6'h3F,  50,  50, 50, 50};

        clr_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();

        check("rst.state", 32'(state), 32'd0);
        check("rst.core_en", 32'(core_en), 32'd0);
        check("rst.prescaler", 32'(prescaler), 32'd10);
        check("rst.half_period", 32'(half_period), 32'd100);
        check("rst.trig", 32'(trig_rate), 32'd0);
        check("rst.wr_ready", 32'(hif.wr_ready), 32'd1);
        check("rst.pend", 32'(hif.commit_pend), 32'd0);
        check_duties("rst", 0, 0, 0, 0);

        // Idle commits: write and commit in the same cycle, apply one edge later
        for (int i = 0; i < 11; i++) begin
            wr(tbl[i].sel, tbl[i].data, 1'b1);
            sbq.push_back(tbl[i]);
            check($sformatf("vec%0d.pend", i), 32'(hif.commit_pend), 32'd1);
            check($sformatf("vec%0d.wr_ready", i), 32'(hif.wr_ready), 32'd0);
            tick();
            ex = sbq.pop_front();
            check($sformatf("vec%0d.pend_clr", i), 32'(hif.commit_pend), 32'd0);
            check($sformatf("vec%0d.pre", i), 32'(prescaler), 32'(ex.pre));
            check($sformatf("vec%0d.hp", i), 32'(half_period), 32'(ex.hp));
            check($sformatf("vec%0d.trig", i), 32'(trig_rate), 32'(ex.trig));
            check_duties($sformatf("vec%0d", i), ex.e0, ex.e1, ex.e2, ex.e3);
        end

        // Write during a pending commit is refused
        wr(3'd0, 15'd11, 1'b1);
        wr(3'd0, 15'd22, 1'b0);
        check("lock.d0", 32'(d0), 32'd11);
        hif.commit = 1'b1; tick(); hif.commit = 1'b0; tick();
        check("lock.recommit_d0", 32'(d0), 32'd11);

        // Atomic update in RUN waits for pwm_sync
        start = 1'b1; tick(); start = 1'b0;
        check("run.state", 32'(state), 32'd1);
        check("run.core_en", 32'(core_en), 32'd1);
        wr(3'd0, 15'd99, 1'b0);
        wr(3'd1, 15'd98, 1'b0);
        wr(3'd2, 15'd0, 1'b0);
        wr(3'd3, 15'd1, 1'b1);
        check("run.wr_ready", 32'(hif.wr_ready), 32'd0);
        tick(); tick(); tick();
        check("run.pend_hold", 32'(hif.commit_pend), 32'd1);
        check_duties("run.hold", 11, 50, 50, 50);
        sync_pulse();
        check("run.pend_clr", 32'(hif.commit_pend), 32'd0);
`ifdef SERVO_PWM_SOFTSTART_EN
        check_duties("run.ramp1", 17, 56, 44, 44);
`else
        check_duties("run.apply", 99, 98, 0, 1);
`endif

        // Graceful stop (stop beats start), commit held through the drain
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check("stop.state_drain", 32'(state), 32'd2);
        wr(3'd0, 15'd10, 1'b1);
        check("stop.pend", 32'(hif.commit_pend), 32'd1);
        sync_pulse();
        check("stop.state_off", 32'(state), 32'd3);
        check("stop.core_en1", 32'(core_en), 32'd1);
        check_duties("stop.sync1", 0, 0, 0, 0);
        sync_pulse();
        check("stop.state_idle", 32'(state), 32'd0);
        check("stop.core_en2", 32'(core_en), 32'd0);
        check("stop.pend_held", 32'(hif.commit_pend), 32'd1);
        tick();
        check("stop.pend_clr", 32'(hif.commit_pend), 32'd0);
        check_duties("stop.idle_apply", 10, 98, 0, 1);

        // start+stop in IDLE both ignored
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check("idle_ss.state", 32'(state), 32'd0);

        // Fault beats start; fault_clr ignored while fault is high
        fault = 1'b1; start = 1'b1; tick(); start = 1'b0;
        check("fault.state", 32'(state), 32'd4);
        check("fault.core_en", 32'(core_en), 32'd0);
        check_duties("fault", 0, 0, 0, 0);
        fault_clr = 1'b1; tick();
        check("fault.clr_ignored", 32'(state), 32'd4);
        fault = 1'b0; tick(); fault_clr = 1'b0;
        check("fault.cleared", 32'(state), 32'd0);
        check("fault.d1_stays0", 32'(d1), 32'd0);
        hif.commit = 1'b1; tick(); hif.commit = 1'b0; tick();
        check_duties("fault.recommit", 10, 98, 0, 1);

        // Async reset mid-RUN drops core_en without a clock edge
        start = 1'b1; tick(); start = 1'b0;
        check("arst.pre_core_en", 32'(core_en), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst.core_en", 32'(core_en), 32'd0);
        check("arst.state", 32'(state), 32'd0);
        check("arst.d0", 32'(d0), 32'd0);
        check("arst.prescaler", 32'(prescaler), 32'd10);
        tick();
        reset = 1'b0;
        tick();
        check("arst.half_period", 32'(half_period), 32'd100);

`ifdef SERVO_PWM_SOFTSTART_EN
        // Soft-start ramp: step = 100/16 = 6 per sync
        start = 1'b1; tick(); start = 1'b0;
        wr(3'd0, 15'd50, 1'b1);
        exp_d = 0;
        for (int k = 0; k < 9; k++) begin
            sync_pulse();
            exp_d = (exp_d + 6 > 50) ? 50 : exp_d + 6;
            check($sformatf("soft.d0_%0d", k), 32'(d0), 32'(exp_d));
        end
`else
        exp_d = 0;
        check("nosoft.d0", 32'(d0), 32'(exp_d));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish within 200000 time units");
        $fatal(1);
    end

endmodule
